vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_pkg.sv | 55 +++++
 rtl/vga_timing_gen_pipe_delay.sv | 46 ++++
 rtl/vga_timing_gen.sv | 150 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_pkg
// Shared types and constants for the VGA raster timing generator.
//   vga_mode_t   : porch/sync geometry of a video mode plus its pixel clock.
//   vga_strobe_t : the six per-pixel strobes carried through the delay line.
//   MODE_*       : geometry of the standard modes the labkit drives.
//   in_window()  : half-open range test used by the sync decoders.
// -----------------------------------------------------------------------------
package vga_timing_gen_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        int unsigned pclk_khz;
    } vga_mode_t;

    // Bit order matches the {hsync, vsync, blank_b, line_start, frame_start,
    // sync_b} bundle that travels through the delay line.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_b;
        logic line_start;
        logic frame_start;
        logic sync_b;
    } vga_strobe_t;

    localparam vga_mode_t MODE_640X480_72 = '{
        h_active: 640, h_fp: 24, h_sync: 40,  h_bp: 128,
        v_active: 480, v_fp: 9,  v_sync: 3,   v_bp: 28,  pclk_khz: 31500};
    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,  pclk_khz: 25175};
    localparam vga_mode_t MODE_800X600_72 = '{
        h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
        v_active: 600, v_fp: 37, v_sync: 6,   v_bp: 23,  pclk_khz: 50000};
    localparam vga_mode_t MODE_1024X768_60 = '{
        h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
        v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29, pclk_khz: 65000};

    // True when lo <= val < lo + len. Done at 32 bits so a window that ends
    // exactly at 2^CW cannot wrap.
    function automatic logic in_window(input int unsigned val,
                                       input int unsigned lo,
                                       input int unsigned len);
        return (val >= lo) && (val < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pipe_delay.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_pipe_delay
// Enabled shift register of DEPTH stages, each WIDTH bits, that all reset to
// RESET_VAL. When DEPTH is 0 it is a wire and the clock, reset and enable
// ports go unused.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous reset, active-low
//   i_en    : shift enable; low holds every stage
//   i_d     : data in
//   o_q     : data out, DEPTH enabled cycles after i_d
// -----------------------------------------------------------------------------
module vga_timing_gen_pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_pass
        logic w_unused_ok;
        assign w_unused_ok = ^{i_clk, i_rst_n, i_en};
        assign o_q = i_d;
    end else begin : g_pipe
        logic [DEPTH-1:0][WIDTH-1:0] r_stage;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_stage <= {DEPTH{RESET_VAL}};
            end else if (i_en) begin
                r_stage[0] <= i_d;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_q = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parameterised VGA raster timing generator in the pixel_clock domain.
// Counts pixel columns and lines, and decodes the sync, blank and start
// strobes. The strobes pass through a DELAY-stage line so they stay aligned
// with a multi-stage pixel pipeline. hcount and vcount are never delayed.
// Optional build macro: VGA_TIMING_COMPOSITE_SYNC_EN. When it is defined,
// sync_b carries the XOR composite sync used by sync-on-green monitors.
// When it is undefined, sync_b is tied high.
// Ports:
//   pixel_clock : pixel clock
//   reset_b     : asynchronous reset, active-low
//   en          : count enable; low freezes counters and delay stages
//   hcount      : current pixel column (undelayed)
//   vcount      : current line (undelayed)
//   hsync       : horizontal sync, polarity HSYNC_POL, delayed DELAY cycles
//   vsync       : vertical sync, polarity VSYNC_POL, delayed
//   blank_b     : high inside the active area, delayed
//   line_start  : one-cycle pulse at hcount == 0, delayed
//   frame_start : one-cycle pulse at hcount == 0 && vcount == 0, delayed
//   sync_b      : composite sync, active-low, delayed
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 24,
    parameter int unsigned H_SYNC    = 40,
    parameter int unsigned H_BP      = 128,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 9,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BP      = 28,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int          DELAY     = 0,
    parameter int          CW        = 11
) (
    input  logic          pixel_clock,
    input  logic          reset_b,
    input  logic          en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_b,
    output logic          line_start,
    output logic          frame_start,
    output logic          sync_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam vga_strobe_t STRB_RST = '{
        hsync:       ~HSYNC_POL,
        vsync:       ~VSYNC_POL,
        blank_b:     1'b0,
        line_start:  1'b0,
        frame_start: 1'b0,
        sync_b:      1'b1
    };

    // Elaboration-time guards on the geometry.
    if ((64'd1 << CW) < 64'(H_TOTAL) || (64'd1 << CW) < 64'(V_TOTAL)) begin : g_cw_bad
        $error("vga_timing_gen: CW=%0d too narrow for H_TOTAL=%0d / V_TOTAL=%0d",
               CW, H_TOTAL, V_TOTAL);
    end
    if (DELAY < 0 || DELAY > 15) begin : g_delay_bad
        $error("vga_timing_gen: DELAY=%0d outside 0..15", DELAY);
    end

    logic [CW-1:0] r_hcount;
    logic [CW-1:0] r_vcount;
    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_v_nxt;
    logic          w_h_wrap;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_act;
    vga_strobe_t   w_strb_nxt;
    vga_strobe_t   r_strb;
    vga_strobe_t   w_strb_dly;

    always_comb begin
        w_h_wrap = (r_hcount == CW'(H_TOTAL - 1));
        w_h_nxt  = w_h_wrap ? '0 : r_hcount + CW'(1);
        w_v_nxt  = r_vcount;
        if (w_h_wrap) begin
            w_v_nxt = (r_vcount == CW'(V_TOTAL - 1)) ? '0 : r_vcount + CW'(1);
        end
    end

    // The strobe register loads on the same edge as the counters. So the
    // strobes are decoded from the counter values being loaded. That keeps
    // the DELAY=0 strobes in step with hcount/vcount and still registered.
    always_comb begin
        w_hs_act = in_window(32'(w_h_nxt), H_ACTIVE + H_FP, H_SYNC);
        w_vs_act = in_window(32'(w_v_nxt), V_ACTIVE + V_FP, V_SYNC);
        w_act    = (32'(w_h_nxt) < H_ACTIVE) && (32'(w_v_nxt) < V_ACTIVE);

        w_strb_nxt             = STRB_RST;
        w_strb_nxt.hsync       = w_hs_act ^ ~HSYNC_POL;
        w_strb_nxt.vsync       = w_vs_act ^ ~VSYNC_POL;
        w_strb_nxt.blank_b     = w_act;
        w_strb_nxt.line_start  = (w_h_nxt == '0);
        w_strb_nxt.frame_start = (w_h_nxt == '0) && (w_v_nxt == '0);
`ifdef VGA_TIMING_COMPOSITE_SYNC_EN
        // Low during hsync on normal lines, and inverted (serration) during
        // vsync lines.
        w_strb_nxt.sync_b      = ~(w_hs_act ^ w_vs_act);
`else
        w_strb_nxt.sync_b      = 1'b1;
`endif
    end

    always_ff @(posedge pixel_clock or negedge reset_b) begin
        if (!reset_b) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_strb   <= STRB_RST;
        end else if (en) begin
            r_hcount <= w_h_nxt;
            r_vcount <= w_v_nxt;
            r_strb   <= w_strb_nxt;
        end
    end

    vga_timing_gen_pipe_delay #(
        .WIDTH     ($bits(vga_strobe_t)),
        .DEPTH     (DELAY),
        .RESET_VAL (STRB_RST)
    ) u_dly (
        .i_clk   (pixel_clock),
        .i_rst_n (reset_b),
        .i_en    (en),
        .i_d     (r_strb),
        .o_q     (w_strb_dly)
    );

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = w_strb_dly.hsync;
    assign vsync       = w_strb_dly.vsync;
    assign blank_b     = w_strb_dly.blank_b;
    assign line_start  = w_strb_dly.line_start;
    assign frame_start = w_strb_dly.frame_start;
    assign sync_b      = w_strb_dly.sync_b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances share one stimulus, both in a reduced video mode: u_d0 has
// DELAY=0 and active-low syncs, u_d3 has DELAY=3 and active-high syncs.
// A raster model pushes the expected strobe bundle for each enabled cycle
// into a per-instance queue. The queue for u_d3 is pre-loaded with DELAY
// reset entries, so popping on each enabled cycle gives the value the
// delayed output should show.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 4;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 25
    localparam int VT = VA + VF + VS + VB;   // 15
    localparam int CW = 5;
    localparam int DLY3 = 3;

    // {hsync, vsync, blank_b, line_start, frame_start, sync_b} at reset
    localparam logic [5:0] R0 = 6'b110001;   // active-low syncs idle high
    localparam logic [5:0] R3 = 6'b000001;   // active-high syncs idle low

    logic          pixel_clock = 1'b0;
    logic          reset_b;
    logic          en;
    logic [CW-1:0] hc0, vc0, hc3, vc3;
    logic          hs0, vs0, bl0, ls0, fs0, sb0;
    logic          hs3, vs3, bl3, ls3, fs3, sb3;

    always #5 pixel_clock = ~pixel_clock;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .DELAY(0), .CW(CW)
    ) u_d0 (
        .pixel_clock(pixel_clock), .reset_b(reset_b), .en(en),
        .hcount(hc0), .vcount(vc0), .hsync(hs0), .vsync(vs0),
        .blank_b(bl0), .line_start(ls0), .frame_start(fs0), .sync_b(sb0)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .DELAY(DLY3), .CW(CW)
    ) u_d3 (
        .pixel_clock(pixel_clock), .reset_b(reset_b), .en(en),
        .hcount(hc3), .vcount(vc3), .hsync(hs3), .vsync(vs3),
        .blank_b(bl3), .line_start(ls3), .frame_start(fs3), .sync_b(sb3)
    );

    int n_chk;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- raster model + scoreboard ----------------
    int         mh, mv;
    logic [5:0] q0[$];
    logic [5:0] q3[$];
    logic [5:0] e0, e3;
    int         c_bl, c_ls, c_fs, c_hs, c_vs;

    function automatic logic [5:0] model_strb(input int h, input int v,
                                             input bit hpol, input bit vpol);
        bit hsa, vsa, act, sb;
        hsa = (h >= HA + HF) && (h < HA + HF + HS);
        vsa = (v >= VA + VF) && (v < VA + VF + VS);
        act = (h < HA) && (v < VA);
`ifdef VGA_TIMING_COMPOSITE_SYNC_EN
        sb  = !(hsa ^ vsa);
`else
        sb  = 1'b1;
`endif
        return {hsa ? hpol : !hpol, vsa ? vpol : !vpol, act,
                h == 0, (h == 0) && (v == 0), sb};
    endfunction

    task automatic model_reset();
        mh = 0;
        mv = 0;
        q0.delete();
        q3.delete();
        e0 = R0;
        e3 = R3;
        for (int i = 0; i < DLY3; i++) q3.push_back(R3);
    endtask

    task automatic compare_all();
        chk("hcount_d0", 32'(hc0), 32'(mh));
        chk("vcount_d0", 32'(vc0), 32'(mv));
        chk("hcount_d3", 32'(hc3), 32'(mh));
        chk("vcount_d3", 32'(vc3), 32'(mv));
        chk("strobes_d0", 32'({hs0, vs0, bl0, ls0, fs0, sb0}), 32'(e0));
        chk("strobes_d3", 32'({hs3, vs3, bl3, ls3, fs3, sb3}), 32'(e3));
    endtask

    // One clock. Inputs change only #1 after an edge, so the en and reset_b
    // values seen here are the ones the DUT sampled.
    task automatic tick();
        @(posedge pixel_clock);
        #1;
        if (reset_b && en) begin
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
            q0.push_back(model_strb(mh, mv, 1'b0, 1'b0));
            q3.push_back(model_strb(mh, mv, 1'b1, 1'b1));
            e0 = q0.pop_front();
            e3 = q3.pop_front();
            c_bl += int'(bl0);
            c_ls += int'(ls0);
            c_fs += int'(fs0);
            c_hs += int'(!hs0);
            c_vs += int'(!vs0);
        end
        compare_all();
    endtask

    // One full frame of enabled cycles. If hold is set, en is dropped for
    // 10 cycles inside the first hsync pulse.
    task automatic run_frame(input bit hold);
        int  n;
        bit  held;
        n    = 0;
        held = 1'b0;
        c_bl = 0; c_ls = 0; c_fs = 0; c_hs = 0; c_vs = 0;
        while (n < HT * VT) begin
            tick();
            n++;
            if (hold && !held && mh == HA + HF + 1) begin
                en = 1'b0;
                repeat (10) tick();
                en   = 1'b1;
                held = 1'b1;
            end
        end
        chk("blank_cycles",  32'(c_bl), 32'(HA * VA));
        chk("line_starts",   32'(c_ls), 32'(VT));
        chk("frame_starts",  32'(c_fs), 32'(1));
        chk("hsync_cycles",  32'(c_hs), 32'(HS * VT));
        chk("vsync_cycles",  32'(c_vs), 32'(VS * HT));
        if (hold) chk("hold_seen", 32'(held), 32'(1));
    endtask

    initial begin
        bit found;
        n_chk   = 0;
        n_fail  = 0;
        reset_b = 1'b0;
        en      = 1'b0;
        model_reset();
        repeat (2) @(posedge pixel_clock);
        #1;
        compare_all();                 // reset state

        reset_b = 1'b1;
        en      = 1'b1;
        run_frame(1'b0);               // clean frame incl. wrap to 0,0
        run_frame(1'b1);               // frame with en held low inside hsync

        // Asynchronous reset in the middle of a line.
        found = 1'b0;
        for (int i = 0; i < HT * VT && !found; i++) begin
            tick();
            if (mh == 12 && mv == 5) found = 1'b1;
        end
        chk("reach_mid_line", 32'(found), 32'(1));
        reset_b = 1'b0;
        #1;
        model_reset();
        compare_all();                 // inactive before the next edge
        tick();                        // held in reset across an edge
        reset_b = 1'b1;
        run_frame(1'b0);               // restart frame

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
